halut_result_collector: RTL and testbench
=========================================

Name: halut_result_collector

Overview:
Downstream of the HALUT matmul array. Gathers the FP32 results that the DecUnitsX decoder lanes emit out of order, each tagged with a global m address, into one M-word row buffer. Once all M columns are present, it streams the row out in ascending m order over a valid/ready interface. It raises busy_o so the controller stalls the encoder while the row drains.

Parameters:
M, halut_pkg::M, number of output columns per row
DecoderUnits, halut_pkg::DecoderUnits, decoder units per lane
DecUnitsX, M / DecoderUnits, number of input lanes (derived, do not override)
MAddrWidth, $clog2(M), width of m addresses (derived)
ResultWidth, halut_pkg::ResultWidth (32), FP32 word width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
result_i  in  ResultWidth x DecUnitsX  per-lane FP32 result
valid_i  in  1 x DecUnitsX  per-lane result valid
m_addr_i  in  MAddrWidth x DecUnitsX  per-lane global column index
busy_o  out  1  high while draining; upstream must not issue results
data_o  out  ResultWidth  current output word
data_valid_o  out  1  output word valid
data_ready_i  in  1  downstream accepts the word
data_idx_o  out  MAddrWidth  column index of data_o
data_last_o  out  1  data_o is column M-1
row_done_o  out  1  one-cycle pulse after the last word is accepted
dup_err_o  out  1  sticky: duplicate or out-of-range address
overrun_err_o  out  1  sticky: result arrived while draining
err_clear_i  in  1  clears both sticky error flags

Behaviour:
- Reset (async, rst_i=1):
  - state=COLLECT; filled bitmap=0; rd_ptr=0.
  - All outputs are 0.
  - Buffer contents are not reset; they are never observable before being filled.
- FSM states: COLLECT, DRAIN.
- COLLECT:
  - For each lane x with valid_i[x], with a = m_addr_i[x]:
    - a >= M -> drop the write; set dup_err_o.
    - filled[a] already 1 -> drop the write; set dup_err_o.
    - Two or more lanes hit the same a in one cycle -> the lowest lane index writes; the others are dropped; set dup_err_o.
    - Otherwise -> buffer[a]=result_i[x] and filled[a]=1 at the clock edge.
  - All lanes can write distinct addresses in the same cycle.
  - If the bitmap (including this cycle's writes) becomes all-ones -> state=DRAIN on the next edge.
- DRAIN:
  - busy_o=1 and data_valid_o=1.
  - data_o=buffer[rd_ptr], data_idx_o=rd_ptr, data_last_o=(rd_ptr==M-1).
  - data_o and data_idx_o stay stable while data_valid_o && !data_ready_i.
  - On a handshake, rd_ptr increments.
  - On the last handshake: filled=0, rd_ptr=0, state=COLLECT, and row_done_o=1 in the following cycle only.
  - Any valid_i during DRAIN is dropped and sets overrun_err_o; the buffer is unchanged.
- Latency: the edge that completes the bitmap is followed by data_valid_o=1 in the next cycle. With data_ready_i held high, a row drains in exactly M cycles.
- busy_o is registered: it equals (state==DRAIN).
- Sticky errors: err_clear_i clears both flags. If a set and a clear occur in the same cycle, set wins.
- Reset asserted mid-drain aborts the row: no row_done_o, and the bitmap is cleared.
- Results are passed through bit-exact; the block does no arithmetic on data.

Decomposition:
- halut_pkg gains:
  - ResultWidth=32.
  - The enum collector_state_e {COLLECT, DRAIN}.
- One sub-module, halut_result_bank: an M x ResultWidth register file with DecUnitsX write ports (per-port enable and address, lowest port wins), one combinational read port, and no reset.
- Bitmap, arbitration, FSM and error logic stay in the top module.

Test Plan:
Bench configuration: M=32, DecoderUnits=16, DecUnitsX=2.
- In-order fill: lane0 m=0..15 and lane1 m=16..31 concurrently, data=0x3F800000+m -> data_valid_o rises one cycle after the 16th write. Words are output with idx 0..31 and data 0x3F800000..0x3F80001F; data_last_o=1 only at idx 31; one row_done_o pulse.
- Scrambled order: both lanes issue a random permutation of 0..31 -> output is still in idx order 0..31 with matching data; busy_o=1 for exactly 32 cycles with ready held high.
- Backpressure: data_ready_i toggles 1,0,0,1,... -> data_o/data_idx_o hold while ready=0; all 32 words are delivered with none lost or repeated.
- Duplicate/collision: lane0 and lane1 both write m=5 in one cycle (values 0xA, 0xB), then lane0 rewrites m=5 with 0xC -> word 5 outputs 0xA; dup_err_o=1; after err_clear_i, dup_err_o=0.
- Overrun and reset: valid_i=1 during DRAIN -> overrun_err_o=1 and the output row is unchanged. Asserting rst_i at idx 10 of a drain -> all outputs 0 immediately; the next 32 fresh writes produce a complete row.

Source files
------------

// File: rtl/halut_pkg.sv
// -----------------------------------------------------------------------------
// halut_pkg
// Shared configuration for the HALUT datapath: array geometry, result word
// width and the result-collector state type.
// No ports (package).
// -----------------------------------------------------------------------------
package halut_pkg;

    // Output columns per row produced by the matmul array.
    localparam int unsigned M            = 32;
    // Decoder units served by one decoder lane.
    localparam int unsigned DecoderUnits = 16;
    // FP32 result word.
    localparam int unsigned ResultWidth  = 32;

    typedef enum logic {
        COLLECT,
        DRAIN
    } collector_state_e;

endpackage

// File: rtl/halut_result_collector_if.sv
// -----------------------------------------------------------------------------
// halut_result_collector_if
// Bundles the decoder-lane result inputs and the ascending-order output stream
// of the result collector.
//   result_i / valid_i / m_addr_i : per-lane tagged results (producer -> collector)
//   data_o / data_valid_o / data_idx_o / data_last_o : row stream (collector -> sink)
//   data_ready_i : sink accepts the current word
// Modports: master = producer/sink side, slave = collector side.
// -----------------------------------------------------------------------------
interface halut_result_collector_if
    import halut_pkg::*;
#(
    parameter int unsigned NumLanes  = halut_pkg::M / halut_pkg::DecoderUnits,
    parameter int unsigned AddrWidth = $clog2(halut_pkg::M),
    parameter int unsigned DataWidth = halut_pkg::ResultWidth
) ();

    logic [NumLanes-1:0][DataWidth-1:0] result_i;
    logic [NumLanes-1:0]                valid_i;
    logic [NumLanes-1:0][AddrWidth-1:0] m_addr_i;

    logic [DataWidth-1:0]               data_o;
    logic                               data_valid_o;
    logic                               data_ready_i;
    logic [AddrWidth-1:0]               data_idx_o;
    logic                               data_last_o;

    modport master (
        output result_i,
        output valid_i,
        output m_addr_i,
        output data_ready_i,
        input  data_o,
        input  data_valid_o,
        input  data_idx_o,
        input  data_last_o
    );

    modport slave (
        input  result_i,
        input  valid_i,
        input  m_addr_i,
        input  data_ready_i,
        output data_o,
        output data_valid_o,
        output data_idx_o,
        output data_last_o
    );

endinterface

// File: rtl/halut_result_bank.sv
// -----------------------------------------------------------------------------
// halut_result_bank
// Depth x Width register file holding one row of results.
//   i_clk      : clock
//   i_wr_en    : per-port write enable
//   i_wr_addr  : per-port write address
//   i_wr_data  : per-port write data
//   i_rd_addr  : combinational read address
//   o_rd_data  : combinational read data
// Several ports writing the same address in one cycle: the lowest port wins.
// Contents are not reset; the owner only reads entries it has written.
// -----------------------------------------------------------------------------
module halut_result_bank
    import halut_pkg::*;
#(
    parameter int unsigned Depth     = halut_pkg::M,
    parameter int unsigned Width     = halut_pkg::ResultWidth,
    parameter int unsigned NumPorts  = 2,
    localparam int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                               i_clk,
    input  logic [NumPorts-1:0]                i_wr_en,
    input  logic [NumPorts-1:0][AddrWidth-1:0] i_wr_addr,
    input  logic [NumPorts-1:0][Width-1:0]     i_wr_data,
    input  logic [AddrWidth-1:0]               i_rd_addr,
    output logic [Width-1:0]                   o_rd_data
);

    logic [Width-1:0] r_mem [Depth];

    // Walk ports from highest to lowest so the lowest port's NBA lands last.
    always_ff @(posedge i_clk) begin
        for (int p = int'(NumPorts) - 1; p >= 0; p--) begin
            if (i_wr_en[p]) begin
                r_mem[i_wr_addr[p]] <= i_wr_data[p];
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/halut_result_collector.sv
// -----------------------------------------------------------------------------
// halut_result_collector
// Gathers out-of-order tagged FP32 results from the decoder lanes into one
// M-word row, then streams the row out in ascending column order.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   bus (slave)     : lane inputs and valid/ready output stream
//   busy_o          : high while the row drains; upstream must hold off
//   row_done_o      : one-cycle pulse after the last word is accepted
//   dup_err_o       : sticky, duplicate / colliding / out-of-range address
//   overrun_err_o   : sticky, result arrived while draining
//   err_clear_i     : clears both sticky flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module halut_result_collector
    import halut_pkg::*;
#(
    parameter int unsigned  M            = halut_pkg::M,
    parameter int unsigned  DecoderUnits = halut_pkg::DecoderUnits,
    parameter int unsigned  ResultWidth  = halut_pkg::ResultWidth,
    localparam int unsigned DecUnitsX    = M / DecoderUnits,
    localparam int unsigned MAddrWidth   = $clog2(M)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    halut_result_collector_if.slave   bus,
    output logic                      busy_o,
    output logic                      row_done_o,
    output logic                      dup_err_o,
    output logic                      overrun_err_o,
    input  logic                      err_clear_i
);

    collector_state_e        r_state, w_state_next;
    logic [M-1:0]            r_filled, w_filled_next;
    logic [MAddrWidth-1:0]   r_rd_ptr, w_rd_ptr_next;
    logic                    r_row_done, w_row_done_next;
    logic                    r_dup_err, w_dup_err_next;
    logic                    r_overrun_err, w_overrun_err_next;

    logic [DecUnitsX-1:0]    w_wr_en;
    logic [M-1:0]            w_wr_mask;
    logic                    w_dup_set;
    logic                    w_overrun_set;
    logic                    w_drain;
    logic                    w_handshake;
    logic                    w_last_beat;
    logic [ResultWidth-1:0]  w_rd_data;

    function automatic logic addr_in_range(input logic [MAddrWidth-1:0] a);
        return 32'(a) < M;
    endfunction

    // Per-lane write arbitration. A lane loses if its address is out of range,
    // already filled, or also claimed by a lower-indexed valid lane this cycle.
    always_comb begin
        w_wr_en       = '0;
        w_wr_mask     = '0;
        w_dup_set     = 1'b0;
        w_overrun_set = 1'b0;
        for (int x = 0; x < int'(DecUnitsX); x++) begin
            if (bus.valid_i[x]) begin
                if (r_state == DRAIN) begin
                    w_overrun_set = 1'b1;
                end else begin
                    w_wr_en[x] = addr_in_range(bus.m_addr_i[x])
                                 && !r_filled[bus.m_addr_i[x]];
                    for (int y = 0; y < x; y++) begin
                        if (bus.valid_i[y] && (bus.m_addr_i[y] == bus.m_addr_i[x])) begin
                            w_wr_en[x] = 1'b0;
                        end
                    end
                    if (w_wr_en[x]) begin
                        w_wr_mask[bus.m_addr_i[x]] = 1'b1;
                    end else begin
                        w_dup_set = 1'b1;
                    end
                end
            end
        end
    end

    // FSM next-state, bitmap and read pointer.
    always_comb begin
        w_state_next    = r_state;
        w_filled_next   = r_filled;
        w_rd_ptr_next   = r_rd_ptr;
        w_row_done_next = 1'b0;
        w_drain         = (r_state == DRAIN);
        w_handshake     = w_drain && bus.data_ready_i;
        w_last_beat     = w_handshake && (32'(r_rd_ptr) == M - 1);
        unique case (r_state)
            COLLECT: begin
                w_filled_next = r_filled | w_wr_mask;
                if (&w_filled_next) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_beat) begin
                    w_filled_next   = '0;
                    w_rd_ptr_next   = '0;
                    w_state_next    = COLLECT;
                    w_row_done_next = 1'b1;
                end else if (w_handshake) begin
                    w_rd_ptr_next = r_rd_ptr + 1'b1;
                end
            end
        endcase
    end

    // Sticky error flags: a set in the same cycle as a clear wins.
    always_comb begin
        w_dup_err_next     = w_dup_set     | (r_dup_err     & ~err_clear_i);
        w_overrun_err_next = w_overrun_set | (r_overrun_err & ~err_clear_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= COLLECT;
            r_filled      <= '0;
            r_rd_ptr      <= '0;
            r_row_done    <= 1'b0;
            r_dup_err     <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_filled      <= w_filled_next;
            r_rd_ptr      <= w_rd_ptr_next;
            r_row_done    <= w_row_done_next;
            r_dup_err     <= w_dup_err_next;
            r_overrun_err <= w_overrun_err_next;
        end
    end

    halut_result_bank #(
        .Depth    (M),
        .Width    (ResultWidth),
        .NumPorts (DecUnitsX)
    ) u_bank (
        .i_clk     (clk_i),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (bus.m_addr_i),
        .i_wr_data (bus.result_i),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Data is gated outside DRAIN so unwritten bank entries never leak out.
    assign busy_o           = (r_state == DRAIN);
    assign bus.data_valid_o = (r_state == DRAIN);
    assign bus.data_o       = (r_state == DRAIN) ? w_rd_data : '0;
    assign bus.data_idx_o   = r_rd_ptr;
    assign bus.data_last_o  = (r_state == DRAIN) && (32'(r_rd_ptr) == M - 1);
    assign row_done_o       = r_row_done;
    assign dup_err_o        = r_dup_err;
    assign overrun_err_o    = r_overrun_err;

endmodule

// File: tb/tb_halut_result_collector.sv
// -----------------------------------------------------------------------------
// tb_halut_result_collector
// Directed bench for halut_result_collector with M=32, two decoder lanes.
// -----------------------------------------------------------------------------
module tb_halut_result_collector;
    import halut_pkg::*;

    localparam int unsigned AW = $clog2(M);

    logic clk = 1'b0;
    logic rst;
    logic err_clear;
    logic busy, row_done, dup_err, overrun_err;

    halut_result_collector_if bus ();

    halut_result_collector dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus),
        .busy_o        (busy),
        .row_done_o    (row_done),
        .dup_err_o     (dup_err),
        .overrun_err_o (overrun_err),
        .err_clear_i   (err_clear)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_row [32];
    int          perm [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input bit v0, input logic [AW-1:0] a0, input logic [31:0] d0,
                             input bit v1, input logic [AW-1:0] a1, input logic [31:0] d1);
        bus.valid_i     = {v1, v0};
        bus.m_addr_i[0] = a0;
        bus.m_addr_i[1] = a1;
        bus.result_i[0] = d0;
        bus.result_i[1] = d1;
    endtask

    task automatic idle_lanes();
        bus.valid_i = '0;
    endtask

    // Lane0 fills 0..15, lane1 fills 16..31; valid must appear only after the 16th write.
    task automatic fill_inorder(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            exp_row[i]      = base + 32'(i);
            exp_row[16 + i] = base + 32'(16 + i);
            set_lanes(1'b1, AW'(i), exp_row[i], 1'b1, AW'(16 + i), exp_row[16 + i]);
            tick();
            check("fill_valid", 32'(bus.data_valid_o), 32'(i == 15));
        end
        idle_lanes();
    endtask

    // Drains one row against exp_row; bp selects ready pattern 1,0,0,1,0,0,...
    task automatic drain_row(input bit bp, input bit chk_busy, input string tag);
        int k = 0;
        int busy_cycles = 0;
        int cyc = 0;
        while (k < 32 && cyc < 200) begin
            bus.data_ready_i = bp ? (cyc % 3 == 0) : 1'b1;
            check({tag, "_valid"}, 32'(bus.data_valid_o), 32'd1);
            check({tag, "_idx"}, 32'(bus.data_idx_o), 32'(k));
            check({tag, "_data"}, bus.data_o, exp_row[k]);
            check({tag, "_last"}, 32'(bus.data_last_o), 32'(k == 31));
            check({tag, "_rowdone_mid"}, 32'(row_done), 32'd0);
            if (busy) busy_cycles++;
            if (bus.data_ready_i && bus.data_valid_o) k++;
            cyc++;
            tick();
        end
        check({tag, "_words"}, 32'(k), 32'd32);
        if (chk_busy) check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd32);
        check({tag, "_rowdone"}, 32'(row_done), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_valid_end"}, 32'(bus.data_valid_o), 32'd0);
        bus.data_ready_i = 1'b0;
        tick();
        check({tag, "_rowdone_pulse"}, 32'(row_done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        err_clear        = 1'b0;
        bus.valid_i      = '0;
        bus.m_addr_i     = '0;
        bus.result_i     = '0;
        bus.data_ready_i = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(bus.data_valid_o), 32'd0);
        check("rst_data", bus.data_o, 32'd0);
        check("rst_idx", 32'(bus.data_idx_o), 32'd0);
        check("rst_last", 32'(bus.data_last_o), 32'd0);
        check("rst_rowdone", 32'(row_done), 32'd0);
        check("rst_dup", 32'(dup_err), 32'd0);
        check("rst_overrun", 32'(overrun_err), 32'd0);
        rst = 1'b0;
        tick();

        // In-order fill and drain
        fill_inorder(32'h3F80_0000);
        check("inorder_busy", 32'(busy), 32'd1);
        drain_row(1'b0, 1'b1, "inorder");

        // Scrambled fill
        for (int i = 0; i < 32; i++) perm[i] = i;
        for (int i = 31; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < 32; i++) exp_row[perm[i]] = 32'h4000_0000 + 32'(perm[i] * 7);
        for (int i = 0; i < 16; i++) begin
            set_lanes(1'b1, AW'(perm[i]), exp_row[perm[i]],
                      1'b1, AW'(perm[16 + i]), exp_row[perm[16 + i]]);
            tick();
            check("scr_fill_valid", 32'(bus.data_valid_o), 32'(i == 15));
        end
        idle_lanes();
        check("scr_dup", 32'(dup_err), 32'd0);
        drain_row(1'b0, 1'b1, "scr");

        // Backpressure
        fill_inorder(32'hC000_0000);
        drain_row(1'b1, 1'b0, "bp");

        // Duplicate / collision
        set_lanes(1'b1, AW'(5), 32'hA, 1'b1, AW'(5), 32'hB);
        tick();
        check("dup_collide", 32'(dup_err), 32'd1);
        check("dup_busy", 32'(busy), 32'd0);
        set_lanes(1'b1, AW'(5), 32'hC, 1'b0, AW'(0), 32'h0);
        tick();
        idle_lanes();
        check("dup_rewrite", 32'(dup_err), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("dup_clear", 32'(dup_err), 32'd0);
        set_lanes(1'b1, AW'(5), 32'hD, 1'b0, AW'(0), 32'h0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        idle_lanes();
        check("dup_set_wins", 32'(dup_err), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("dup_clear2", 32'(dup_err), 32'd0);
        for (int i = 0; i < 16; i++) begin
            exp_row[i]      = (i == 5) ? 32'hA : 32'h1000 + 32'(i);
            exp_row[16 + i] = 32'h1000 + 32'(16 + i);
            set_lanes(i != 5, AW'(i), exp_row[i], 1'b1, AW'(16 + i), exp_row[16 + i]);
            tick();
            check("dup_fill_valid", 32'(bus.data_valid_o), 32'(i == 15));
        end
        idle_lanes();
        check("dup_after_fill", 32'(dup_err), 32'd0);
        drain_row(1'b0, 1'b1, "dup");

        // Overrun during drain
        fill_inorder(32'h5000_0000);
        bus.data_ready_i = 1'b0;
        set_lanes(1'b1, AW'(3), 32'hDEAD, 1'b1, AW'(20), 32'hBEEF);
        tick();
        idle_lanes();
        check("ovr_flag", 32'(overrun_err), 32'd1);
        check("ovr_no_dup", 32'(dup_err), 32'd0);
        check("ovr_hold_idx", 32'(bus.data_idx_o), 32'd0);
        drain_row(1'b0, 1'b0, "ovr");
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("ovr_clear", 32'(overrun_err), 32'd0);

        // Reset mid-drain
        fill_inorder(32'h6000_0000);
        bus.data_ready_i = 1'b1;
        repeat (10) tick();
        check("rstd_idx10", 32'(bus.data_idx_o), 32'd10);
        check("rstd_data10", bus.data_o, 32'h6000_000A);
        rst = 1'b1;
        #1;
        check("rstd_busy", 32'(busy), 32'd0);
        check("rstd_valid", 32'(bus.data_valid_o), 32'd0);
        check("rstd_data", bus.data_o, 32'd0);
        check("rstd_idx", 32'(bus.data_idx_o), 32'd0);
        check("rstd_last", 32'(bus.data_last_o), 32'd0);
        check("rstd_rowdone", 32'(row_done), 32'd0);
        bus.data_ready_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("rstd_no_rowdone", 32'(row_done), 32'd0);
        fill_inorder(32'h7000_0000);
        drain_row(1'b0, 1'b1, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
